// File: rtl/crtl_pkg.sv
// crtl_pkg: opcode/funct constants, control-field encodings and the packed
// control word shared by the decoder and the control register.
package crtl_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CTL_W = 19;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
  localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
  localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
  localparam logic [OP_W-1:0] OP_LHU   = 6'b100101;
  localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
  localparam logic [OP_W-1:0] OP_SH    = 6'b101001;

  // R-type funct codes
  localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [OP_W-1:0] FN_SLTU = 6'b101011;
  localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] FN_JR   = 6'b001000;
  localparam logic [OP_W-1:0] FN_JALR = 6'b001001;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_SLL  = 4'b0110
  } aluop_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10
  } extop_e;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC8 = 2'b10
  } memtoreg_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_NPC = 2'b01,
    PC_RS  = 2'b10
  } pcsrc_e;

  typedef enum logic [2:0] {
    LS_WORD = 3'b000,
    LS_HS   = 3'b001,
    LS_HU   = 3'b010,
    LS_BS   = 3'b011,
    LS_BU   = 3'b100
  } lstype_e;

  typedef struct packed {
    memtoreg_e memtoreg;
    logic      memwrite;
    logic      alusrc;
    aluop_e    aluop;
    extop_e    extop;
    regdst_e   regdst;
    logic      regwrite;
    pcsrc_e    pcsrc;
    logic      npcsrc;
    lstype_e   lstype;
  } ctrl_t;

endpackage

// File: rtl/crtl_dec.sv
// crtl_dec: combinational opcode/funct to control-word decoder.
// Ports: opcode_i, funct_i -> ctrl_c (unregistered control word).
// Macro CRTL_LS_EXT_EN enables lb/lbu/lh/lhu/sb/sh decoding.
module crtl_dec
  import crtl_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  input  logic [OP_W-1:0] funct_i,
  output ctrl_t           ctrl_c
);

  // Anything not matched below stays all-zero (NOP).
  always_comb begin
    ctrl_c = '0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_c.regdst   = DST_RD;
        ctrl_c.regwrite = 1'b1;
        case (funct_i)
          FN_ADDU: ctrl_c.aluop = ALU_ADD;
          FN_SUBU: ctrl_c.aluop = ALU_SUB;
          FN_AND:  ctrl_c.aluop = ALU_AND;
          FN_OR:   ctrl_c.aluop = ALU_OR;
          FN_SLT:  ctrl_c.aluop = ALU_SLT;
          FN_SLTU: ctrl_c.aluop = ALU_SLTU;
          FN_SLL:  ctrl_c.aluop = ALU_SLL;
          FN_JR: begin
            ctrl_c.pcsrc    = PC_RS;
            ctrl_c.regwrite = 1'b0;
            ctrl_c.regdst   = DST_RT;
          end
          FN_JALR: begin
            ctrl_c.pcsrc    = PC_RS;
            ctrl_c.memtoreg = WB_PC8;
          end
          default: ctrl_c = '0;
        endcase
      end
      OP_ADDIU: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.extop    = EXT_SIGN;
        ctrl_c.aluop    = ALU_ADD;
        ctrl_c.regwrite = 1'b1;
      end
      OP_ANDI: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.extop    = EXT_ZERO;
        ctrl_c.aluop    = ALU_AND;
        ctrl_c.regwrite = 1'b1;
      end
      OP_ORI: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.extop    = EXT_ZERO;
        ctrl_c.aluop    = ALU_OR;
        ctrl_c.regwrite = 1'b1;
      end
      OP_LUI: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.extop    = EXT_LUI;
        ctrl_c.aluop    = ALU_OR;
        ctrl_c.regwrite = 1'b1;
      end
      OP_LW: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.extop    = EXT_SIGN;
        ctrl_c.aluop    = ALU_ADD;
        ctrl_c.memtoreg = WB_MEM;
        ctrl_c.regwrite = 1'b1;
        ctrl_c.lstype   = LS_WORD;
      end
      OP_SW: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.extop    = EXT_SIGN;
        ctrl_c.aluop    = ALU_ADD;
        ctrl_c.memwrite = 1'b1;
        ctrl_c.lstype   = LS_WORD;
      end
      OP_BEQ: begin
        ctrl_c.aluop  = ALU_SUB;
        ctrl_c.extop  = EXT_SIGN;
        ctrl_c.pcsrc  = PC_NPC;
        ctrl_c.npcsrc = 1'b0;
      end
      OP_J: begin
        ctrl_c.pcsrc  = PC_NPC;
        ctrl_c.npcsrc = 1'b1;
      end
      OP_JAL: begin
        ctrl_c.pcsrc    = PC_NPC;
        ctrl_c.npcsrc   = 1'b1;
        ctrl_c.regdst   = DST_RA;
        ctrl_c.memtoreg = WB_PC8;
        ctrl_c.regwrite = 1'b1;
      end
`ifdef CRTL_LS_EXT_EN
      OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.extop    = EXT_SIGN;
        ctrl_c.aluop    = ALU_ADD;
        ctrl_c.memtoreg = WB_MEM;
        ctrl_c.regwrite = 1'b1;
        case (opcode_i)
          OP_LB:   ctrl_c.lstype = LS_BS;
          OP_LBU:  ctrl_c.lstype = LS_BU;
          OP_LH:   ctrl_c.lstype = LS_HS;
          default: ctrl_c.lstype = LS_HU;
        endcase
      end
      OP_SB, OP_SH: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.extop    = EXT_SIGN;
        ctrl_c.aluop    = ALU_ADD;
        ctrl_c.memwrite = 1'b1;
        ctrl_c.lstype   = (opcode_i == OP_SB) ? LS_BS : LS_HS;
      end
`endif
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/crtl.sv
// crtl: main instruction decoder with registered control outputs.
// Inputs: clk, rst_n (async active-low), en (load/stall), flush (load NOP,
// beats en), OPCode, FunctCode. Outputs: registered datapath control fields.
// Macro CRTL_LS_EXT_EN enables the sub-word load/store instructions.
module crtl
  import crtl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       flush,
  input  logic [5:0] OPCode,
  input  logic [5:0] FunctCode,
  output logic [1:0] MemtoReg,
  output logic       MemWrite,
  output logic       ALUsrc,
  output logic [3:0] ALUop,
  output logic [1:0] EXTop,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic [1:0] PCsrc,
  output logic       NPCsrc,
  output logic [2:0] LStype
);

  ctrl_t dec_c;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  crtl_dec u_dec (
    .opcode_i (OPCode),
    .funct_i  (FunctCode),
    .ctrl_c   (dec_c)
  );

  // flush bubbles, en loads, otherwise hold (stall)
  always_comb begin
    ctrl_d = ctrl_q;
    if (flush) begin
      ctrl_d = '0;
    end else if (en) begin
      ctrl_d = dec_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign MemtoReg = ctrl_q.memtoreg;
  assign MemWrite = ctrl_q.memwrite;
  assign ALUsrc   = ctrl_q.alusrc;
  assign ALUop    = ctrl_q.aluop;
  assign EXTop    = ctrl_q.extop;
  assign RegDst   = ctrl_q.regdst;
  assign RegWrite = ctrl_q.regwrite;
  assign PCsrc    = ctrl_q.pcsrc;
  assign NPCsrc   = ctrl_q.npcsrc;
  assign LStype   = ctrl_q.lstype;

endmodule

// File: tb/tb_crtl.sv
// tb_crtl: directed scoreboard bench for crtl. Stimulus pushes the
// hand-computed control word; a monitor pops and compares after each edge.
module tb_crtl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic [5:0] OPCode;
  logic [5:0] FunctCode;
  logic [1:0] MemtoReg;
  logic       MemWrite;
  logic       ALUsrc;
  logic [3:0] ALUop;
  logic [1:0] EXTop;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic [1:0] PCsrc;
  logic       NPCsrc;
  logic [2:0] LStype;

  int n_checks = 0;
  int n_fails  = 0;

  logic [18:0] exp_q[$];
  string       name_q[$];

  crtl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .OPCode    (OPCode),
    .FunctCode (FunctCode),
    .MemtoReg  (MemtoReg),
    .MemWrite  (MemWrite),
    .ALUsrc    (ALUsrc),
    .ALUop     (ALUop),
    .EXTop     (EXTop),
    .RegDst    (RegDst),
    .RegWrite  (RegWrite),
    .PCsrc     (PCsrc),
    .NPCsrc    (NPCsrc),
    .LStype    (LStype)
  );

  always #5 clk = ~clk;

  // Field order: MemtoReg MemWrite ALUsrc ALUop EXTop RegDst RegWrite PCsrc NPCsrc LStype
  function automatic logic [18:0] w(input logic [1:0] mt, input logic mw,
                                    input logic as, input logic [3:0] alu,
                                    input logic [1:0] ext, input logic [1:0] rd,
                                    input logic rw, input logic [1:0] pc,
                                    input logic np, input logic [2:0] ls);
    return {mt, mw, as, alu, ext, rd, rw, pc, np, ls};
  endfunction

  function automatic logic [18:0] got();
    return {MemtoReg, MemWrite, ALUsrc, ALUop, EXTop, RegDst, RegWrite,
            PCsrc, NPCsrc, LStype};
  endfunction

  task automatic check(input string name, input logic [18:0] act,
                       input logic [18:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one instruction before the edge and queue the expected result.
  task automatic step(input string name, input logic [5:0] op,
                      input logic [5:0] fn, input logic e, input logic f,
                      input logic [18:0] exp);
    @(negedge clk);
    OPCode    = op;
    FunctCode = fn;
    en        = e;
    flush     = f;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // Monitor: outputs are valid right after each rising edge.
  initial begin
    logic [18:0] e;
    string       n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, got(), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [18:0] ZERO = 19'd0;

  initial begin
    logic [18:0] w_ori, w_lui, w_lbu, w_sb;
    w_ori = w(2'b00, 0, 1, 4'b0010, 2'b00, 2'b00, 1, 2'b00, 0, 3'b000);
    w_lui = w(2'b00, 0, 1, 4'b0010, 2'b10, 2'b00, 1, 2'b00, 0, 3'b000);
`ifdef CRTL_LS_EXT_EN
    w_lbu = w(2'b01, 0, 1, 4'b0000, 2'b01, 2'b00, 1, 2'b00, 0, 3'b100);
    w_sb  = w(2'b00, 1, 1, 4'b0000, 2'b01, 2'b00, 0, 2'b00, 0, 3'b011);
`else
    w_lbu = ZERO;
    w_sb  = ZERO;
`endif

    rst_n = 1'b0; en = 1'b1; flush = 1'b0;
    OPCode = 6'b001101; FunctCode = 6'b000000;
    #3;
    check("reset_initial", got(), ZERO);
    @(negedge clk);
    rst_n = 1'b1;

    step("jalr", 6'b000000, 6'b001001, 1, 0,
         w(2'b10, 0, 0, 4'b0000, 2'b00, 2'b01, 1, 2'b10, 0, 3'b000));
    step("lw", 6'b100011, 6'b000000, 1, 0,
         w(2'b01, 0, 1, 4'b0000, 2'b01, 2'b00, 1, 2'b00, 0, 3'b000));
    step("sw", 6'b101011, 6'b000000, 1, 0,
         w(2'b00, 1, 1, 4'b0000, 2'b01, 2'b00, 0, 2'b00, 0, 3'b000));
    step("beq", 6'b000100, 6'b000000, 1, 0,
         w(2'b00, 0, 0, 4'b0001, 2'b01, 2'b00, 0, 2'b01, 0, 3'b000));
    step("jal", 6'b000011, 6'b000000, 1, 0,
         w(2'b10, 0, 0, 4'b0000, 2'b00, 2'b10, 1, 2'b01, 1, 3'b000));
    step("j", 6'b000010, 6'b000000, 1, 0,
         w(2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 2'b01, 1, 3'b000));
    step("addu", 6'b000000, 6'b100001, 1, 0,
         w(2'b00, 0, 0, 4'b0000, 2'b00, 2'b01, 1, 2'b00, 0, 3'b000));
    step("subu", 6'b000000, 6'b100011, 1, 0,
         w(2'b00, 0, 0, 4'b0001, 2'b00, 2'b01, 1, 2'b00, 0, 3'b000));
    step("and", 6'b000000, 6'b100100, 1, 0,
         w(2'b00, 0, 0, 4'b0011, 2'b00, 2'b01, 1, 2'b00, 0, 3'b000));
    step("or", 6'b000000, 6'b100101, 1, 0,
         w(2'b00, 0, 0, 4'b0010, 2'b00, 2'b01, 1, 2'b00, 0, 3'b000));
    step("slt", 6'b000000, 6'b101010, 1, 0,
         w(2'b00, 0, 0, 4'b0100, 2'b00, 2'b01, 1, 2'b00, 0, 3'b000));
    step("sltu", 6'b000000, 6'b101011, 1, 0,
         w(2'b00, 0, 0, 4'b0101, 2'b00, 2'b01, 1, 2'b00, 0, 3'b000));
    step("sll_nop", 6'b000000, 6'b000000, 1, 0,
         w(2'b00, 0, 0, 4'b0110, 2'b00, 2'b01, 1, 2'b00, 0, 3'b000));
    step("jr", 6'b000000, 6'b001000, 1, 0,
         w(2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 2'b10, 0, 3'b000));
    step("bad_funct", 6'b000000, 6'b111111, 1, 0, ZERO);
    step("addiu", 6'b001001, 6'b000000, 1, 0,
         w(2'b00, 0, 1, 4'b0000, 2'b01, 2'b00, 1, 2'b00, 0, 3'b000));
    step("andi", 6'b001100, 6'b000000, 1, 0,
         w(2'b00, 0, 1, 4'b0011, 2'b00, 2'b00, 1, 2'b00, 0, 3'b000));
    step("ori", 6'b001101, 6'b000000, 1, 0, w_ori);
    step("stall_hold", 6'b001111, 6'b000000, 0, 0, w_ori);
    step("lui", 6'b001111, 6'b000000, 1, 0, w_lui);
    step("flush_over_en", 6'b001101, 6'b000000, 1, 1, ZERO);
    step("lbu", 6'b100100, 6'b000000, 1, 0, w_lbu);
    step("sb", 6'b101000, 6'b000000, 1, 0, w_sb);
    step("op_111111", 6'b111111, 6'b000000, 1, 0, ZERO);

    // Reset asserted during a stall: clears immediately and stays clear.
    step("ori_pre_stall", 6'b001101, 6'b000000, 1, 0, w_ori);
    step("stall_pre_reset", 6'b001111, 6'b000000, 0, 0, w_ori);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async_mid_stall", got(), ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    step("stall_after_reset", 6'b001111, 6'b000000, 0, 0, ZERO);
    step("lui_after_reset", 6'b001111, 6'b000000, 1, 0, w_lui);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expected words never checked, required 0",
               exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
